// File: rtl/icache_pkg.sv
// Shared types and width helpers for the set-associative instruction cache.
package icache_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } icache_state_t;

    // Word-offset bits inside a block
    function automatic int woff_w(input int words);
        return $clog2(words);
    endfunction

    // Set-index bits
    function automatic int idx_w(input int sets);
        return $clog2(sets);
    endfunction

    // Tag bits left over from a 30-bit word address
    function automatic int tag_w(input int words, input int sets);
        return 30 - $clog2(words) - $clog2(sets);
    endfunction

    // Pointer width that never collapses to zero bits
    function automatic int ptr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int DEF_WORDS = 2;
    localparam int DEF_SETS  = 8;
    localparam int DEF_TAG_W = tag_w(DEF_WORDS, DEF_SETS);

    // Line layout for the default geometry
    typedef struct packed {
        logic                        valid;
        logic [DEF_TAG_W-1:0]        tag;
        logic [DEF_WORDS-1:0][31:0]  data;
    } icache_line_t;

endpackage

// File: rtl/icache_assoc_chk.sv
// Run-time checks for icache_assoc: the way-hit vector must be one-hot or empty.
module icache_assoc_chk #(
    parameter int WAYS  = 2,
    parameter int CPUID = 0
) (
    input logic            CLK,
    input logic            RST,
    input logic            imemREN_i,
    input logic [WAYS-1:0] hit_vec_i
);

    // A tag present in two ways of one set means the fill logic duplicated a line
    always @(posedge CLK) begin
        assert (RST || !imemREN_i || $onehot0(hit_vec_i))
            else $error("icache cpu%0d: multiple ways hit %b", CPUID, hit_vec_i);
    end

endmodule

// File: rtl/icache_victim.sv
// Victim selection for one set: first invalid way wins, otherwise the
// round-robin pointer of that set.
module icache_victim
    import icache_pkg::*;
#(
    parameter int WAYS = 2
) (
    input  logic [WAYS-1:0]         valid_i,
    input  logic [ptr_w(WAYS)-1:0]  rr_i,
    output logic [ptr_w(WAYS)-1:0]  victim_o,
    output logic                    all_valid_o
);

    localparam int WPW = ptr_w(WAYS);

    logic found_s;

    // Scan ways from 0 upward for a free slot, fall back to round-robin
    always_comb begin
        victim_o = rr_i;
        found_s  = 1'b0;
        for (int w = 0; w < WAYS; w++) begin
            if (!found_s && !valid_i[w]) begin
                victim_o = WPW'(w);
                found_s  = 1'b1;
            end else begin
                found_s  = found_s;
            end
        end
        all_valid_o = &valid_i;
    end

endmodule

// File: rtl/icache_assoc.sv
// N-way set-associative instruction cache with multi-word blocks, burst
// refill FSM, per-set round-robin replacement and single-cycle flush.
module icache_assoc
    import icache_pkg::*;
#(
    parameter int WAYS  = 2,
    parameter int SETS  = 8,
    parameter int WORDS = 2,
    parameter int CPUID = 0
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        imemREN,
    input  logic [31:0] imemaddr,
    input  logic        iflush,
    output logic        ihit,
    output logic [31:0] imemload,
    output logic        iREN,
    output logic [31:0] iaddr,
    input  logic        iwait,
    input  logic [31:0] iload
);

    localparam int WOFF    = woff_w(WORDS);
    localparam int IDX     = idx_w(SETS);
    localparam int TAGW    = tag_w(WORDS, SETS);
    localparam int WPW     = ptr_w(WAYS);
    localparam int CNTW    = ptr_w(WORDS);
    localparam int LSB_IDX = 2 + WOFF;
    localparam int LSB_TAG = 2 + WOFF + IDX;

    // Address fields of the current fetch
    logic [IDX-1:0]   set_s;
    logic [TAGW-1:0]  tag_s;
    logic [CNTW-1:0]  word_s;
    logic [31:0]      base_s;
    logic             unused_addr_s;

    assign set_s         = imemaddr[LSB_TAG-1:LSB_IDX];
    assign tag_s         = imemaddr[31:LSB_TAG];
    assign base_s        = {imemaddr[31:LSB_IDX], {LSB_IDX{1'b0}}};
    assign unused_addr_s = ^imemaddr[1:0];

    generate
        if (WOFF > 0) begin : g_woff
            assign word_s = imemaddr[LSB_IDX-1:2];
        end else begin : g_nowoff
            assign word_s = {CNTW{1'b0}};
        end
    endgenerate

    // Line storage
    logic [WAYS-1:0]  valid_q [SETS];
    logic [TAGW-1:0]  tags_q  [SETS][WAYS];
    logic [31:0]      data_q  [SETS][WAYS][WORDS];

    // Fill FSM and context
    icache_state_t    state_q, state_d;
    logic [CNTW-1:0]  cnt_q,   cnt_d;
    logic [31:0]      base_q,  base_d;
    logic [IDX-1:0]   fset_q,  fset_d;
    logic [TAGW-1:0]  ftag_q,  ftag_d;
    logic [WPW-1:0]   vict_q,  vict_d;
    logic             allv_q,  allv_d;
    logic [31:0]      buf_q [WORDS];
    logic [31:0]      buf_d [WORDS];
    logic             write_line_s;

    // Lookup and victim signals
    logic [WAYS-1:0]  hit_vec_s;
    logic             hit_any_s;
    logic [31:0]      way_data_s;
    logic [WPW-1:0]   rr_cur_s;
    logic [WPW-1:0]   victim_s;
    logic             all_valid_s;

    icache_victim #(.WAYS(WAYS)) u_victim (
        .valid_i     (valid_q[set_s]),
        .rr_i        (rr_cur_s),
        .victim_o    (victim_s),
        .all_valid_o (all_valid_s)
    );

    icache_assoc_chk #(.WAYS(WAYS), .CPUID(CPUID)) u_chk (
        .CLK       (CLK),
        .RST       (RST),
        .imemREN_i (imemREN),
        .hit_vec_i (hit_vec_s)
    );

    // Tag compare across all ways of the addressed set; hit data is OR-merged
    always_comb begin
        hit_vec_s  = {WAYS{1'b0}};
        way_data_s = 32'h0;
        for (int w = 0; w < WAYS; w++) begin
            hit_vec_s[w] = valid_q[set_s][w] && (tags_q[set_s][w] == tag_s);
            way_data_s   = way_data_s | (hit_vec_s[w] ? data_q[set_s][w][word_s] : 32'h0);
        end
    end

    assign hit_any_s = |hit_vec_s;
    assign ihit      = imemREN & hit_any_s & (state_q == IDLE) & ~iflush;
    assign imemload  = ihit ? way_data_s : 32'h0;
    assign iREN      = (state_q == FILL);
    assign iaddr     = (state_q == FILL) ? (base_q + (32'(cnt_q) << 2)) : 32'h0;

    // Next-state logic for the refill burst
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        base_d       = base_q;
        fset_d       = fset_q;
        ftag_d       = ftag_q;
        vict_d       = vict_q;
        allv_d       = allv_q;
        buf_d        = buf_q;
        write_line_s = 1'b0;
        case (state_q)
            IDLE: begin
                if (imemREN && !hit_any_s && !iflush) begin
                    state_d = FILL;
                    cnt_d   = {CNTW{1'b0}};
                    base_d  = base_s;
                    fset_d  = set_s;
                    ftag_d  = tag_s;
                    vict_d  = victim_s;
                    allv_d  = all_valid_s;
                end else begin
                    state_d = IDLE;
                end
            end
            FILL: begin
                if (iflush) begin
                    state_d = IDLE;
                    cnt_d   = {CNTW{1'b0}};
                end else if (!iwait) begin
                    buf_d[cnt_q] = iload;
                    if (cnt_q == CNTW'(WORDS - 1)) begin
                        write_line_s = 1'b1;
                        state_d      = IDLE;
                        cnt_d        = {CNTW{1'b0}};
                    end else begin
                        cnt_d = cnt_q + CNTW'(1);
                    end
                end else begin
                    state_d = FILL;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = {CNTW{1'b0}};
            end
        endcase
    end

    // FSM state, word counter and latched fill context
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            cnt_q   <= {CNTW{1'b0}};
            base_q  <= 32'h0;
            fset_q  <= {IDX{1'b0}};
            ftag_q  <= {TAGW{1'b0}};
            vict_q  <= {WPW{1'b0}};
            allv_q  <= 1'b0;
            for (int i = 0; i < WORDS; i++) begin
                buf_q[i] <= 32'h0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            base_q  <= base_d;
            fset_q  <= fset_d;
            ftag_q  <= ftag_d;
            vict_q  <= vict_d;
            allv_q  <= allv_d;
            buf_q   <= buf_d;
        end
    end

    // Valid bits: cleared by reset or flush, set when a completed block lands
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= {WAYS{1'b0}};
            end
        end else if (iflush) begin
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= {WAYS{1'b0}};
            end
        end else if (write_line_s) begin
            valid_q[fset_q][vict_q] <= 1'b1;
        end
    end

    // Tag and data arrays need no reset; valid gates their use
    always_ff @(posedge CLK) begin
        if (write_line_s) begin
            tags_q[fset_q][vict_q] <= ftag_q;
            for (int w = 0; w < WORDS; w++) begin
                data_q[fset_q][vict_q][w] <= buf_d[w];
            end
        end
    end

    generate
        if (WAYS > 1) begin : g_rr
            logic [WPW-1:0] rr_q [SETS];
            assign rr_cur_s = rr_q[set_s];
            // Round-robin advances only when a full set had to evict
            always_ff @(posedge CLK or posedge RST) begin
                if (RST) begin
                    for (int s = 0; s < SETS; s++) begin
                        rr_q[s] <= {WPW{1'b0}};
                    end
                end else if (write_line_s && allv_q) begin
                    rr_q[fset_q] <= (rr_q[fset_q] == WPW'(WAYS - 1)) ? {WPW{1'b0}}
                                                                     : rr_q[fset_q] + WPW'(1);
                end
            end
        end else begin : g_norr
            assign rr_cur_s = {WPW{1'b0}};
        end
    endgenerate

endmodule
